// File: rtl/div_if.sv
// Start/annul handshake and result bus between EX and the multi-cycle divider.
interface div_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle; result is {remainder, quotient}.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_remd;

  always_comb begin
    w_neg1  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    w_neg2  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    w_abs1  = w_neg1 ? (WIDTH'(0) - bus.opdata1_i) : bus.opdata1_i;
    w_abs2  = w_neg2 ? (WIDTH'(0) - bus.opdata2_i) : bus.opdata2_i;
    // Trial subtract: bit WIDTH of the difference is the borrow.
    w_shift = {r_rem, r_dvd[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
    w_qbit  = ~w_diff[WIDTH];
    w_quot  = r_neg_q ? (WIDTH'(0) - r_dvd) : r_dvd;
    w_remd  = r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StFree;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        StFree: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          if (bus.start_i && !bus.annul_i) begin
            r_busy <= 1'b1;
            if (bus.opdata2_i == '0) begin
              r_state <= StByZero;
            end else begin
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_neg1 ^ w_neg2;
              r_neg_r <= w_neg1;
              r_state <= StOn;
            end
          end
        end
        StByZero: begin
          r_busy   <= 1'b0;
          r_result <= '0;
          if (bus.annul_i) begin
            r_state <= StFree;
          end else begin
            r_ready <= 1'b1;
            r_state <= StEnd;
          end
        end
        StOn: begin
          if (bus.annul_i) begin
            r_state  <= StFree;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
          end else if (r_cnt != CntW'(WIDTH)) begin
            r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt + CntW'(1);
          end else begin
            r_result <= {w_remd, w_quot};
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StEnd;
          end
        end
        StEnd: begin
          // Annul is ignored here; only dropping start releases the result.
          if (!bus.start_i) begin
            r_ready  <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_state  <= StFree;
          end
        end
        default: r_state <= StFree;
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
  assign bus.busy_o   = r_busy;
endmodule
